// File: rtl/alu_pkg.sv
// Shared ALU encodings (select codes, ALUOp, funct) for the issue stage and the ALU.
package alu_pkg;

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned SEL_W     = 4;
   localparam int unsigned IMM_W     = 16;
   localparam int unsigned OP_W      = 2;
   localparam int unsigned FUNCT_W   = 6;
   localparam int unsigned REG_IDX_W = 5;

   // ALU select codes
   localparam logic [SEL_W-1:0] SEL_AND = 4'b0000;
   localparam logic [SEL_W-1:0] SEL_OR  = 4'b0001;
   localparam logic [SEL_W-1:0] SEL_ADD = 4'b0010;
   localparam logic [SEL_W-1:0] SEL_SUB = 4'b0110;
   localparam logic [SEL_W-1:0] SEL_SLT = 4'b0111;
   localparam logic [SEL_W-1:0] SEL_NOR = 4'b1100;

   // Main-control ALUOp codes
   localparam logic [OP_W-1:0] ALUOP_MEM   = 2'b00;
   localparam logic [OP_W-1:0] ALUOP_BR    = 2'b01;
   localparam logic [OP_W-1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [OP_W-1:0] ALUOP_ORI   = 2'b11;

   // R-type funct codes
   localparam logic [FUNCT_W-1:0] FUNCT_ADD  = 6'b100000;
   localparam logic [FUNCT_W-1:0] FUNCT_ADDU = 6'b100001;
   localparam logic [FUNCT_W-1:0] FUNCT_SUB  = 6'b100010;
   localparam logic [FUNCT_W-1:0] FUNCT_SUBU = 6'b100011;
   localparam logic [FUNCT_W-1:0] FUNCT_AND  = 6'b100100;
   localparam logic [FUNCT_W-1:0] FUNCT_OR   = 6'b100101;
   localparam logic [FUNCT_W-1:0] FUNCT_NOR  = 6'b100111;
   localparam logic [FUNCT_W-1:0] FUNCT_SLT  = 6'b101010;

   // Operand/select payload handed from the issue stage to the ALU
   typedef struct packed {
      logic [DATA_W-1:0] first;
      logic [DATA_W-1:0] second;
      logic [SEL_W-1:0]  select;
   } issue_t;

   // Extend a 16-bit immediate: zero-extend for logical ops, sign-extend otherwise
   function automatic logic [DATA_W-1:0] extend_imm(input logic [IMM_W-1:0] imm,
                                                    input logic            zero_ext);
      logic [DATA_W-IMM_W-1:0] upper;
      upper = zero_ext ? '0 : {(DATA_W-IMM_W){imm[IMM_W-1]}};
      return {upper, imm};
   endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// ALU-control decode: (ALUOp, funct) -> ALU select code and unsupported-funct flag.
module alu_ctrl_decode
   import alu_pkg::*;
(
   input  logic [OP_W-1:0]    alu_op,
   input  logic [FUNCT_W-1:0] funct,
   output logic [SEL_W-1:0]   select_c,
   output logic               illegal_c
);

   // Map ALUOp first; only R-type instructions consult funct
   always_comb begin
      select_c  = SEL_ADD;
      illegal_c = 1'b0;
      case (alu_op)
         ALUOP_MEM: select_c = SEL_ADD;
         ALUOP_BR:  select_c = SEL_SUB;
         ALUOP_ORI: select_c = SEL_OR;
         default: begin
            case (funct)
               FUNCT_ADD, FUNCT_ADDU: select_c = SEL_ADD;
               FUNCT_SUB, FUNCT_SUBU: select_c = SEL_SUB;
               FUNCT_AND:             select_c = SEL_AND;
               FUNCT_OR:              select_c = SEL_OR;
               FUNCT_NOR:             select_c = SEL_NOR;
               FUNCT_SLT:             select_c = SEL_SLT;
               default: begin
                  select_c  = SEL_ADD;
                  illegal_c = 1'b1;
               end
            endcase
         end
      endcase
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register in front of the 32-bit ALU: decode, immediate extension,
// operand-B mux, stall/flush. Optional EX/MEM forwarding under ALU_ISSUE_FORWARDING_EN.
module alu_issue_stage
   import alu_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 stall,
   input  logic                 flush,
   input  logic                 in_valid,
   input  logic [DATA_W-1:0]    rs_data,
   input  logic [DATA_W-1:0]    rt_data,
   input  logic [IMM_W-1:0]     imm16,
   input  logic [OP_W-1:0]      alu_op,
   input  logic [FUNCT_W-1:0]   funct,
   input  logic                 alu_src,
   input  logic [REG_IDX_W-1:0] rs_idx,
   input  logic [REG_IDX_W-1:0] rt_idx,
   input  logic                 fwd_valid,
   input  logic [REG_IDX_W-1:0] fwd_rd,
   input  logic [DATA_W-1:0]    fwd_data,
   output logic [DATA_W-1:0]    first,
   output logic [DATA_W-1:0]    second,
   output logic [SEL_W-1:0]     select,
   output logic                 out_valid,
   output logic                 illegal
);

   logic [SEL_W-1:0]  dec_select_c;
   logic              dec_illegal_c;
   logic [DATA_W-1:0] rs_op_c;
   logic [DATA_W-1:0] rt_op_c;
   logic [DATA_W-1:0] imm_ext_c;
   issue_t            issue_nxt_c;
   issue_t            issue_q;
   logic              valid_q;
   logic              illegal_q;

   alu_ctrl_decode u_ctrl (
      .alu_op    (alu_op),
      .funct     (funct),
      .select_c  (dec_select_c),
      .illegal_c (dec_illegal_c)
   );

`ifdef ALU_ISSUE_FORWARDING_EN
   // Bypass the EX/MEM result onto a matching source operand; r0 never forwards
   always_comb begin
      rs_op_c = rs_data;
      rt_op_c = rt_data;
      if (fwd_valid && (fwd_rd != '0) && (fwd_rd == rs_idx)) begin
         rs_op_c = fwd_data;
      end
      if (fwd_valid && (fwd_rd != '0) && (fwd_rd == rt_idx)) begin
         rt_op_c = fwd_data;
      end
   end
`else
   // Forwarding disabled: operands come straight from the register file
   assign rs_op_c = rs_data;
   assign rt_op_c = rt_data;

   logic unused_fwd;
   assign unused_fwd = ^{fwd_valid, fwd_rd, fwd_data, rs_idx, rt_idx};
`endif

   // Immediate extension and operand-B mux; forwarding sits upstream of the mux
   always_comb begin
      imm_ext_c          = extend_imm(imm16, alu_op == ALUOP_ORI);
      issue_nxt_c.first  = rs_op_c;
      issue_nxt_c.second = alu_src ? imm_ext_c : rt_op_c;
      issue_nxt_c.select = dec_select_c;
   end

   // Pipeline register: reset > flush > stall > capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         issue_q.first  <= '0;
         issue_q.second <= '0;
         issue_q.select <= SEL_ADD;
         valid_q        <= 1'b0;
         illegal_q      <= 1'b0;
      end else if (flush) begin
         issue_q   <= '0;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else if (!stall) begin
         issue_q   <= issue_nxt_c;
         valid_q   <= in_valid;
         illegal_q <= in_valid & dec_illegal_c;
      end
   end

   assign first     = issue_q.first;
   assign second    = issue_q.second;
   assign select    = issue_q.select;
   assign out_valid = valid_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: driver pushes model predictions, monitor compares.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst_n, stall, flush, in_valid, alu_src, fwd_valid;
   logic [31:0] rs_data, rt_data, fwd_data;
   logic [15:0] imm16;
   logic [1:0]  alu_op;
   logic [5:0]  funct;
   logic [4:0]  rs_idx, rt_idx, fwd_rd;
   logic [31:0] first, second;
   logic [3:0]  select;
   logic        out_valid, illegal;

   typedef struct {
      logic [31:0] first;
      logic [31:0] second;
      logic [3:0]  sel;
      logic        v;
      logic        ill;
      string       tag;
   } exp_t;

   exp_t  sb_q[$];
   exp_t  cur;
   bit    mon_en = 0;
   int    n_tests = 0;
   int    n_fail  = 0;
   logic [3:0] code_of[string];
   string      rtype_name[logic [5:0]];
   logic [5:0] legal_functs[8];

   always #5 clk = ~clk;

   alu_issue_stage dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
      .rs_data(rs_data), .rt_data(rt_data), .imm16(imm16), .alu_op(alu_op),
      .funct(funct), .alu_src(alu_src), .rs_idx(rs_idx), .rt_idx(rt_idx),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
      .first(first), .second(second), .select(select),
      .out_valid(out_valid), .illegal(illegal)
   );

   // Operation name implied by main control and funct ("bad" for unsupported funct)
   function automatic string op_name(input logic [1:0] op, input logic [5:0] fn);
      if (op == 2'b00) return "add";
      if (op == 2'b01) return "sub";
      if (op == 2'b11) return "or";
      if (rtype_name.exists(fn)) return rtype_name[fn];
      return "bad";
   endfunction

   // Predict the registers after the coming rising edge, push, advance to next negedge
   task automatic step(input string tag);
      exp_t        n;
      string       nm;
      logic [31:0] a, b, imm;
      n = cur;
      if (!rst_n) begin
         n.first = 0; n.second = 0; n.sel = 4'b0010; n.v = 0; n.ill = 0;
      end else if (flush) begin
         n.first = 0; n.second = 0; n.sel = 4'b0000; n.v = 0; n.ill = 0;
      end else if (!stall) begin
         nm = op_name(alu_op, funct);
         a = rs_data;
         b = rt_data;
`ifdef ALU_ISSUE_FORWARDING_EN
         if (fwd_valid && fwd_rd != 0 && fwd_rd == rs_idx) a = fwd_data;
         if (fwd_valid && fwd_rd != 0 && fwd_rd == rt_idx) b = fwd_data;
`endif
         if (alu_op == 2'b11) imm = {16'h0000, imm16};
         else                 imm = {{16{imm16[15]}}, imm16};
         n.first  = a;
         n.second = alu_src ? imm : b;
         n.sel    = (nm == "bad") ? code_of["add"] : code_of[nm];
         n.v      = in_valid;
         n.ill    = in_valid && (nm == "bad");
      end
      n.tag = tag;
      cur = n;
      sb_q.push_back(n);
      mon_en = 1;
      @(negedge clk);
   endtask

   task automatic set_rtype(input logic [5:0] fn);
      in_valid = 1; alu_op = 2'b10; funct = fn; alu_src = 0;
      rs_data = 32'h0000000A; rt_data = 32'h00000003;
   endtask

   // Monitor: compare every registered output set just after each rising edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_tests++;
            if ({first, second, select, out_valid, illegal} !== {e.first, e.second, e.sel, e.v, e.ill}) begin
               n_fail++;
               $display("FAIL %s: got first=%h second=%h select=%b valid=%b illegal=%b, want first=%h second=%h select=%b valid=%b illegal=%b",
                        e.tag, first, second, select, out_valid, illegal,
                        e.first, e.second, e.sel, e.v, e.ill);
            end
            if (illegal === 1'b1 && out_valid !== 1'b1) begin
               n_fail++;
               $display("FAIL %s_illegal_without_valid: got illegal=1 valid=%b, want valid=1", e.tag, out_valid);
            end
         end else if (mon_en) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty: got no expectation, want one per cycle");
         end
      end
   end

   initial begin
      code_of["and"] = 4'b0000; code_of["or"]  = 4'b0001; code_of["add"] = 4'b0010;
      code_of["sub"] = 4'b0110; code_of["slt"] = 4'b0111; code_of["nor"] = 4'b1100;
      rtype_name[6'b100000] = "add"; rtype_name[6'b100001] = "add";
      rtype_name[6'b100010] = "sub"; rtype_name[6'b100011] = "sub";
      rtype_name[6'b100100] = "and"; rtype_name[6'b100101] = "or";
      rtype_name[6'b100111] = "nor"; rtype_name[6'b101010] = "slt";
      legal_functs = '{6'b100000, 6'b100001, 6'b100010, 6'b100011,
                       6'b100100, 6'b100101, 6'b100111, 6'b101010};
      cur = '{first: 0, second: 0, sel: 0, v: 0, ill: 0, tag: "init"};

      rst_n = 0; stall = 1; flush = 0; in_valid = 1; alu_src = 0;
      rs_data = 32'h11111111; rt_data = 32'h22222222; imm16 = 16'h1234;
      alu_op = 2'b10; funct = 6'b100000; rs_idx = 0; rt_idx = 0;
      fwd_valid = 0; fwd_rd = 0; fwd_data = 0;
      @(negedge clk);

      // Reset held with stall and in_valid asserted
      step("reset0");
      step("reset1");
      rst_n = 1; stall = 0;

      // R-type sweep
      set_rtype(6'b100000); step("rtype_add");
      set_rtype(6'b100010); step("rtype_sub");
      set_rtype(6'b100100); step("rtype_and");
      set_rtype(6'b100101); step("rtype_or");
      set_rtype(6'b100111); step("rtype_nor");
      set_rtype(6'b101010); step("rtype_slt");
      set_rtype(6'b000000); step("rtype_illegal");
      set_rtype(6'b000000); in_valid = 0; step("rtype_illegal_novalid");

      // Immediate extension
      in_valid = 1; alu_src = 1; imm16 = 16'hFFFE; alu_op = 2'b00; step("imm_sext");
      alu_op = 2'b11; step("imm_zext_ori");
      alu_op = 2'b01; imm16 = 16'h7FFF; step("imm_pos_beq");

      // Stall holds a captured instruction while inputs change
      set_rtype(6'b100010); rs_data = 32'hA5A5A5A5; step("capture_A");
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         rs_data = $urandom; rt_data = $urandom; funct = 6'b100100; alu_op = 2'(i);
         step($sformatf("stall_hold%0d", i));
      end
      flush = 1; step("flush_and_stall");
      flush = 0; stall = 0; set_rtype(6'b000000); step("capture_illegal");
      flush = 1; step("flush_clears_illegal");
      flush = 0;

      // Reset in the middle of a stall
      set_rtype(6'b100101); step("capture_B");
      stall = 1; rst_n = 0; step("midstall_reset");
      rst_n = 1; step("post_reset_stall");
      stall = 0;

      // Forwarding cases (expectation depends on whether forwarding is built in)
      set_rtype(6'b100000); rs_data = 32'h0BADF00D; rt_data = 32'h00C0FFEE;
      rs_idx = 5; rt_idx = 7; fwd_valid = 1; fwd_rd = 5; fwd_data = 32'h12345678;
      step("fwd_rs_match");
      fwd_rd = 0; rs_idx = 0; step("fwd_rd_zero");
      fwd_rd = 7; rs_idx = 5; step("fwd_rt_match");
      alu_src = 1; imm16 = 16'h8001; step("fwd_rt_imm");
      fwd_valid = 0; alu_src = 0; step("fwd_not_valid");

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         rst_n     = ($urandom_range(0, 49) != 0);
         flush     = ($urandom_range(0, 9) == 0);
         stall     = ($urandom_range(0, 4) == 0);
         in_valid  = 1'($urandom);
         alu_op    = 2'($urandom);
         funct     = ($urandom_range(0, 3) != 0) ? legal_functs[$urandom_range(0, 7)] : 6'($urandom);
         alu_src   = 1'($urandom);
         rs_data   = $urandom;
         rt_data   = $urandom;
         imm16     = 16'($urandom);
         rs_idx    = 5'($urandom_range(0, 3));
         rt_idx    = 5'($urandom_range(0, 3));
         fwd_valid = 1'($urandom);
         fwd_rd    = 5'($urandom_range(0, 3));
         fwd_data  = $urandom;
         step("random");
      end

      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
